// File: rtl/demux_hs_pkg.sv
// Shared helpers for the handshaked demux: channel count and channel data slicing.
// Pure functions, no latency; no flow control of its own.
// Backpressure: not applicable.
package demux_hs_pkg;

    function automatic int num_ch(input int sel_w);
        return 1 << sel_w;
    endfunction

    // Bit offset of channel idx inside the flattened out_data bus.
    function automatic int ch_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/demux_hs_slot.sv
// One output channel: a single-entry holding register with valid flag.
// Latency: load at edge k is visible after edge k.
// Backpressure: free passes out_ready through combinationally, so a full slot can reload each cycle.
module demux_hs_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // A load wins over a departure: the new word replaces the one leaving this cycle.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = load_data;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = dat_q;
    assign free      = !vld_q || out_ready;

endmodule

// File: rtl/demux_hs_param.sv
// Registered 1-to-N demux with unicast/broadcast routing and a saturating accept counter.
// Latency: word accepted at edge k appears on its channel(s) after edge k.
// Backpressure: in_ready = free[in_sel] (unicast) or AND of all free (broadcast); forced low in reset.
module demux_hs_param
    import demux_hs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic [SEL_W-1:0]                 in_sel,
    input  logic                             in_bcast,
    output logic [num_ch(SEL_W)-1:0]         out_valid,
    input  logic [num_ch(SEL_W)-1:0]         out_ready,
    output logic [num_ch(SEL_W)*WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]                 acc_cnt
);

    localparam int N = num_ch(SEL_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     free;
    logic [N-1:0]     load;
    logic             accept;
    logic [CNT_W-1:0] acc_q, acc_d;

    assign in_ready = rst_n && (in_bcast ? &free : free[in_sel]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int i = 0; i < N; i++) begin
            load[i] = accept && (in_bcast || in_sel == SEL_W'(i));
        end
    end

    // A broadcast counts once; the counter sticks at all-ones.
    always_comb begin
        acc_d = acc_q;
        if (accept && acc_q != CNT_MAX) begin
            acc_d = acc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_cnt = acc_q;

    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_hs_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[g]),
            .load_data(in_data),
            .out_ready(out_ready[g]),
            .out_valid(out_valid[g]),
            .out_data (out_data[ch_lo(g, WIDTH) +: WIDTH]),
            .free     (free[g])
        );
    end

endmodule

// File: doc/demux_hs_param.md
Name: demux_hs_param

Overview:
- Parametrised, registered 1-to-N demultiplexer. It is the clocked successor of the 4-way gate-level demux.
- Routes a WIDTH-bit data word to one of N = 2**SEL_W output channels selected by in_sel, or to all channels in broadcast mode.
- Uses valid/ready handshakes on both sides, with a one-entry holding register per channel.
- Sits between a single producer and N independent consumers; full throughput per channel.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- SEL_W, 2, select width; N = 2**SEL_W channels (derived localparam, not overridable)
- CNT_W, 16, width of the accepted-transfer counter (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  word to route
- in_sel  input  SEL_W  destination channel index
- in_bcast  input  1  1 = deliver to all N channels (in_sel ignored)
- out_valid  output  N  bit i: channel i holds a word
- out_ready  input  N  bit i: consumer i takes the word
- out_data  output  N*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- acc_cnt  output  CNT_W  number of accepted input transfers, saturating

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid = 0, out_data = 0, acc_cnt = 0 immediately.
  - in_ready = 0 while rst_n is low.
  - Reset mid-transfer discards all held words; nothing is delivered after release.
- Channel free condition: free[i] = !out_valid[i] || out_ready[i]. This is a combinational ready pass-through, so back-to-back words to the same channel stream at 1 word/cycle.
- in_ready:
  - Unicast: free[in_sel].
  - Broadcast: AND of free[i] over all i.
  - in_ready does not depend on in_valid.
- Accept = in_valid && in_ready, sampled on the rising clk edge.
- Per channel i on each edge:
  - If accept and (bcast or in_sel == i): out_data[i] <= in_data, out_valid[i] <= 1. This holds even when the old word leaves the same cycle.
  - Else if out_ready[i]: out_valid[i] <= 0, out_data[i] holds its value.
  - Else: hold.
- Latency: a word accepted at edge k is visible on out_valid/out_data after edge k.
- Ordering: per channel, words are delivered in acceptance order. Channels are independent; a stalled channel blocks only unicast traffic to itself, plus all broadcasts.
- Stability:
  - out_data[i] must not change while out_valid[i] && !out_ready[i].
  - Producer rule: in_data, in_sel and in_bcast are held stable while in_valid && !in_ready. The bench checks this with an assertion; the RTL does not depend on it.
- acc_cnt:
  - +1 per accept; a broadcast counts as one transfer.
  - Saturates at 2**CNT_W - 1 with no wrap.
- out_ready[i] while out_valid[i] = 0 has no effect.
- No combinational path from in_valid to out_*. The only combinational paths are out_valid/out_ready/in_sel/in_bcast to in_ready.

Decomposition:
- Package demux_hs_pkg holds:
  - the function computing N from SEL_W;
  - the channel data slice helper (index to bit offset).
- One sub-module, demux_hs_slot (WIDTH param), instantiated N times in a generate loop:
  - holding register plus valid flag;
  - ports clk, rst_n, load, load_data, out_ready, out_valid, out_data, free.
- The top contains select decode, the in_ready reduction and the counter.

Test Plan:
- Reset: assert rst_n=0 mid-stream with ch1 holding 0xA5 -> out_valid=0000, out_data=0, acc_cnt=0, in_ready=0 immediately; after release, in_ready=1 and no stale delivery.
- Routing sweep, all out_ready=1: send 0x11,0x22,0x33,0x44 with in_sel=0..3 on consecutive cycles -> one-hot out_valid 0001,0010,0100,1000 each one cycle later with matching data; acc_cnt=4.
- Backpressure, out_ready[2]=0: send 0x5A to ch2, then 0x6B to ch2 -> 0x6B not accepted and in_ready=0 while ch2 is full; a word to ch0 is still accepted. Release out_ready[2] -> 0x5A leaves, 0x6B is accepted in the same cycle and appears next cycle.
- Broadcast: in_bcast=1, data 0xC3, out_ready=1011 with ch2 full -> in_ready=0. Raise out_ready[2] -> all four channels show 0xC3 next cycle; acc_cnt increments by 1.
- Streaming: 100 random unicast words with random out_ready -> per-channel scoreboard order and data match; throughput is 1/cycle when all ready.
- Saturation: CNT_W=3, 10 accepts -> acc_cnt stops at 7.
